alu_div_iter: RTL
=================

// Module: alu_div_iter
// PURPOSE
//  Iterative, multi-cycle radix-2 restoring integer divider. Replaces the single-cycle
//  combinational divide path in the execute stage so that cycle time no longer depends on it.
//  Covers RV64M DIV/DIVU/REM/REMU and the W forms. Results are fully RISC-V compliant,
//  including divide-by-zero and signed overflow.
//  Uses a valid/ready handshake on both sides and a flush input for pipeline kills.
// PARAMETERS
//  XLEN   64  operand/result width; 32 or 64. With XLEN=32, is_word_i is ignored.
//  CNT_W  7   iteration counter width; must be >= $clog2(XLEN)+1
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous reset, active low
//  flush_i      in   1     abort any operation in progress; discard any pending result
//  in_valid_i   in   1     request valid
//  in_ready_o   out  1     unit can accept a request (high only in IDLE)
//  is_signed_i  in   1     1 = DIV/REM(W), 0 = DIVU/REMU(W)
//  is_word_i    in   1     1 = W form: use a[31:0]/b[31:0], sign-extend the 32-bit result
//  is_rem_i     in   1     1 = return remainder, 0 = return quotient
//  a_i          in   XLEN  dividend
//  b_i          in   XLEN  divisor
//  out_valid_o  out  1     result valid
//  out_ready_i  in   1     consumer accepts the result
//  result_o     out  XLEN  quotient or remainder
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready_o=1, out_valid_o=0, result_o=0, counter=0.
//  Accept: in_valid_i & in_ready_o & ~flush_i at edge T. Opcode and operands are latched at T.
//  FSM states: IDLE, CALC, DONE.
//   IDLE -> DONE  on accept when b==0 or signed overflow (special case).
//   IDLE -> CALC  on any other accept. Counter is loaded with N (N=32 if word, else XLEN).
//   CALC: one quotient bit per cycle; counter decrements; CALC -> DONE when the counter reaches 1.
//   DONE: out_valid_o=1 and result_o held stable; DONE -> IDLE on out_valid_o & out_ready_i.
//  Latency: normal op has out_valid_o high from cycle T+N+1; special case from cycle T+1.
//  Throughput: in_ready_o rises the cycle after the result handshake, so there is no same-cycle reuse.
//  Datapath:
//   - Signed ops divide |a| by |b|.
//   - Quotient is negated if sign(a)!=sign(b); remainder takes the sign of a.
//   - Word forms take the sign from bit 31 and use a 32-bit magnitude.
//   - Every word result is sign-extended from bit 31 inside this block.
//   - Remainder register is XLEN+1 bits; each step shifts left, trial-subtracts b, and restores if negative.
//  Special cases (width W = 32 if word, else XLEN):
//   - b==0: quotient = all ones; remainder = a (sign-extended if word).
//   - Signed, a = most-negative W-bit value, b = -1: quotient = a; remainder = 0.
//  Flush:
//   - Any state goes to IDLE at the next edge; out_valid_o=0 next cycle; the latched op is dropped.
//   - Flush in the same cycle as a request means the request is NOT accepted.
//   - Flush in DONE coinciding with out_ready_i: the result is still dropped (flush wins).
//  Inputs are ignored outside IDLE. Reset mid-CALC returns to IDLE immediately; no partial result escapes.
//  Backpressure: while out_ready_i=0, DONE holds out_valid_o and result_o unchanged indefinitely.
// TESTING
//  1. divu a=100 b=7: result 14, out_valid 65 cycles after accept (XLEN=64); remu gives 2.
//  2. div a=-7 b=2: result 0xFFFF_FFFF_FFFF_FFFD (-3); rem gives 0xFFFF_FFFF_FFFF_FFFF (-1).
//  3. divu b=0, a=5: result 0xFFFF_FFFF_FFFF_FFFF at T+1; remu b=0 gives 5.
//  4. div a=0x8000_0000_0000_0000 b=-1: result 0x8000_0000_0000_0000, rem 0, both at T+1.
//  5. divw a=0x1234_5678_FFFF_FFF9 b=2: result 0xFFFF_FFFF_FFFF_FFFD at T+33; divuw a=0xFFFF_FFFF b=1 gives 0xFFFF_FFFF_FFFF_FFFF.
//  6. Flush at T+10 of a div: no out_valid; in_ready=1 at T+11; next op 9/3 returns 3.
//     Hold out_ready=0 for 20 cycles: result stays stable; releasing it completes exactly one handshake.

Source files
------------

// File: rtl/alu_div_iter.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W forms.
// One quotient bit per cycle; zero divisors and signed overflow bypass the iteration.
module alu_div_iter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            is_signed_i,
    input  logic            is_word_i,
    input  logic            is_rem_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned      WSHIFT   = XLEN - 32;
    localparam bit               HAS_WORD = (XLEN > 32);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(32);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic sgn);
        logic [XLEN-1:0] r;
        r       = {XLEN{sgn & x[31]}};
        r[31:0] = x[31:0];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] x, input logic neg);
        return neg ? (~x + XLEN'(1)) : x;
    endfunction

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  div_q, div_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             word_q, word_d;
    logic             sel_rem_q, sel_rem_d;

    // Request decode
    logic            word_eff;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_a, spec_res;
    logic            a_neg, b_neg, b_zero, b_ones, a_min, ovf;

    always_comb begin
        word_eff = is_word_i & HAS_WORD;
        a_ext    = word_eff ? ext32(a_i, is_signed_i) : a_i;
        b_ext    = word_eff ? ext32(b_i, is_signed_i) : b_i;
        a_neg    = is_signed_i & a_ext[XLEN-1];
        b_neg    = is_signed_i & b_ext[XLEN-1];
        a_mag    = cneg(a_ext, a_neg);
        b_mag    = cneg(b_ext, b_neg);
        b_zero   = word_eff ? (b_i[31:0] == 32'd0) : (b_i == '0);
        b_ones   = word_eff ? (b_i[31:0] == 32'hFFFF_FFFF) : (b_i == '1);
        a_min    = word_eff ? (a_i[31:0] == 32'h8000_0000)
                            : (a_i == {1'b1, {(XLEN-1){1'b0}}});
        ovf      = is_signed_i & a_min & b_ones;
        spec_a   = word_eff ? ext32(a_i, 1'b1) : a_i;
        if (b_zero) begin
            spec_res = is_rem_i ? spec_a : '1;
        end else begin
            spec_res = is_rem_i ? '0 : spec_a;
        end
    end

    // One restoring step; the trial is one bit wider so its sign bit flags "restore"
    logic [XLEN+1:0] shifted, trial;
    logic            q_bit;
    logic [XLEN:0]   rem_step;
    logic [XLEN-1:0] quo_step, res_fin;

    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        trial    = shifted - {2'b00, div_q};
        q_bit    = ~trial[XLEN+1];
        rem_step = q_bit ? trial[XLEN:0] : shifted[XLEN:0];
        quo_step = {quo_q[XLEN-2:0], q_bit};
        res_fin  = sel_rem_q ? cneg(rem_step[XLEN-1:0], neg_rem_q) : cneg(quo_step, neg_quo_q);
        if (word_q) begin
            res_fin = ext32(res_fin, 1'b1);
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        word_d      = word_q;
        sel_rem_d   = sel_rem_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i && in_ready_q) begin
                    in_ready_d = 1'b0;
                    if (b_zero || ovf) begin
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                        result_d    = spec_res;
                    end else begin
                        state_d   = StCalc;
                        cnt_d     = word_eff ? CNT_WORD : CNT_FULL;
                        rem_d     = '0;
                        quo_d     = word_eff ? (a_mag << WSHIFT) : a_mag;
                        div_d     = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        word_d    = word_eff;
                        sel_rem_d = is_rem_i;
                    end
                end
            end
            StCalc: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    result_d    = res_fin;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase

        // Flush wins over accept, iteration and result handshake alike
        if (flush_i) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            word_q      <= 1'b0;
            sel_rem_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            word_q      <= word_d;
            sel_rem_q   <= sel_rem_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;

endmodule
